ntt_wb_addr_gen: RTL and testbench

Write-back address sequencer for the four-pass NTT shuffle in the 32-point butterfly path. The read-side permutation ROM maps `{pass, idx}` to a forward-permuted read index. This block is the other end of that mapping. It sweeps all 128 ROM addresses, drives them to the ROM, and emits the inverse-permuted write index for each entry, so results land back in natural order. It also checks every returned ROM word against the closed-form forward permutation and flags any mismatch.

---
 rtl/ntt_wb_addr_gen.sv | 154 +++++++++++++++
 tb/tb_ntt_wb_addr_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_wb_addr_gen.sv
// Write-back address sequencer for the four-pass 32-point NTT shuffle.
// Sweeps all {pass, idx} permutation-ROM addresses, emits the inverse-permuted
// write index for each entry, and checks every returned ROM word against the
// closed-form forward permutation.
module ntt_wb_addr_gen #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] wr_addr,
  output logic [1:0]            wr_pass,
  output logic                  wr_ena,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned PASS_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    s1_valid;
  logic [PASS_W-1:0]       s1_pass;
  logic [DATA_WIDTH-1:0]   s1_idx;
  logic [DATA_WIDTH-1:0]   wr_addr_q;
  logic                    chk;
  logic                    busy_q;
  logic                    done_q;
  logic                    err_q;

  logic                    adv_c;
  logic                    hs_c;
  logic                    last_c;
  logic [PASS_W-1:0]       cnt_pass_c;
  logic [DATA_WIDTH-1:0]   cnt_idx_c;

  // Forward permutation: what the ROM should return for {p, i}
  function automatic logic [DATA_WIDTH-1:0] fwd_perm(input logic [PASS_W-1:0]     p,
                                                     input logic [DATA_WIDTH-1:0] i);
    logic [DATA_WIDTH-1:0] r;
    r = i;
    case (p)
      2'd1:    r = {i[4:3], i[1], i[0], i[2]};
      2'd2:    r = {i[1:0], i[4:2]};
      default: r = i;
    endcase
    return r;
  endfunction

  // Inverse permutation: destination index that restores natural order
  function automatic logic [DATA_WIDTH-1:0] inv_perm(input logic [PASS_W-1:0]     p,
                                                     input logic [DATA_WIDTH-1:0] i);
    logic [DATA_WIDTH-1:0] r;
    r = i;
    case (p)
      2'd1:    r = {i[4:3], i[0], i[2], i[1]};
      2'd2:    r = {i[2:0], i[4:3]};
      default: r = i;
    endcase
    return r;
  endfunction

  // Advance / handshake decode from registered state only
  always_comb begin
    cnt_pass_c = cnt[ADDR_WIDTH-1 -: PASS_W];
    cnt_idx_c  = cnt[DATA_WIDTH-1:0];
    hs_c       = s1_valid & wr_ready;
    adv_c      = (state == RUN) & (~s1_valid | wr_ready);
    last_c     = (cnt == {ADDR_WIDTH{1'b1}});
  end

  // Sequencer FSM, S1 output stage and ROM cross-check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      s1_valid  <= 1'b0;
      s1_pass   <= '0;
      s1_idx    <= '0;
      wr_addr_q <= '0;
      chk       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // ROM word returned this cycle belongs to the entry now held in S1
      chk <= adv_c;
      if (chk && (rom_data != fwd_perm(s1_pass, s1_idx))) begin
        err_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            cnt    <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (adv_c) begin
            s1_valid  <= 1'b1;
            s1_pass   <= cnt_pass_c;
            s1_idx    <= cnt_idx_c;
            wr_addr_q <= inv_perm(cnt_pass_c, cnt_idx_c);
            cnt       <= cnt + ADDR_WIDTH'(1);
            if (last_c) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (hs_c) begin
            s1_valid <= 1'b0;
            state    <= DONE;
            done_q   <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr = cnt;
  assign wr_addr  = wr_addr_q;
  assign wr_pass  = s1_pass;
  assign wr_ena   = s1_valid;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ntt_wb_addr_gen.sv
// Directed bench for ntt_wb_addr_gen: behavioural ROM, sweep driver with
// stall / reset / start-pulse injection, and a table of hand-computed entries.
module tb_ntt_wb_addr_gen;

  localparam int unsigned DW = 5;
  localparam int unsigned AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] wr_addr;
  logic [1:0]    wr_pass;
  logic          wr_ena;
  logic          wr_ready;
  logic          busy;
  logic          done;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  int fault_addr = -1;

  logic [1:0]    log_pass [128];
  logic [DW-1:0] log_addr [128];

  typedef struct {
    int n;
    int pass;
    int addr;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  ntt_wb_addr_gen #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .wr_addr  (wr_addr),
    .wr_pass  (wr_pass),
    .wr_ena   (wr_ena),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Closed-form forward permutation, bit by bit
  function automatic logic [DW-1:0] ref_fwd(input logic [1:0] p, input logic [DW-1:0] i);
    case (p)
      2'd1:    return {i[4], i[3], i[1], i[0], i[2]};
      2'd2:    return {i[1], i[0], i[4], i[3], i[2]};
      default: return i;
    endcase
  endfunction

  // Permutation ROM with one-cycle registered read and optional bad word
  always @(posedge clk) begin
    if (int'(rom_addr) == fault_addr) rom_data <= '0;
    else                              rom_data <= ref_fwd(rom_addr[6:5], rom_addr[4:0]);
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entries must arrive in order with the pass from the sweep count and an
  // address that the forward map sends back to the entry's idx.
  task automatic verify_log(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      if (int'(log_pass[k]) != k / 32) bad++;
      else if (int'(ref_fwd(log_pass[k], log_addr[k])) != k % 32) bad++;
    end
    check({tag, "_order_bad_entries"}, bad, 0);
  endtask

  task automatic verify_table(input string tag);
    for (int v = 0; v < 12; v++) begin
      check($sformatf("%s_pass_e%0d", tag, vecs[v].n), int'(log_pass[vecs[v].n]), vecs[v].pass);
      check($sformatf("%s_addr_e%0d", tag, vecs[v].n), int'(log_addr[vecs[v].n]), vecs[v].addr);
    end
  endtask

  // One sweep, entered and left at a falling edge. Cycle 1 is the first
  // cycle after start is sampled.
  task automatic sweep(input int stall_at, input int stall_n, input int rst_at,
                       input int pulse_a, input int pulse_b, input bit start_on_done,
                       output int done_cyc, output int err_cyc, output int n_hs);
    int            st;
    logic [DW-1:0] h_addr;
    logic [1:0]    h_pass;
    st = 0; done_cyc = -1; err_cyc = -1; n_hs = 0;
    h_addr = '0; h_pass = '0;
    for (int k = 0; k < 128; k++) begin
      log_pass[k] = '0;
      log_addr[k] = '0;
    end
    start    = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("c1_busy", int'(busy), 1);
    check("c1_rom_addr", int'(rom_addr), 0);
    check("c1_err", int'(err), 0);
    check("c1_wr_ena", int'(wr_ena), 0);
    for (int cyc = 1; cyc < 400; cyc++) begin
      start = (cyc == pulse_a || cyc == pulse_b) ? 1'b1 : 1'b0;
      if (start_on_done && done) start = 1'b1;
      if (cyc == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_wr_ena", int'(wr_ena), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        return;
      end
      if (wr_ena && n_hs == stall_at && st < stall_n) begin
        wr_ready = 1'b0;
        if (st == 0) begin
          h_addr = wr_addr;
          h_pass = wr_pass;
        end else begin
          check("stall_wr_addr", int'(wr_addr), int'(h_addr));
          check("stall_wr_pass", int'(wr_pass), int'(h_pass));
        end
        check("stall_rom_addr", int'(rom_addr), stall_at + 1);
        st++;
      end else begin
        if (stall_n > 0 && st == stall_n && n_hs == stall_at) begin
          check("release_wr_ena", int'(wr_ena), 1);
          check("release_wr_addr", int'(wr_addr), int'(h_addr));
          check("release_wr_pass", int'(wr_pass), int'(h_pass));
        end
        wr_ready = 1'b1;
      end
      if (wr_ena && wr_ready) begin
        if (n_hs < 128) begin
          log_pass[n_hs] = wr_pass;
          log_addr[n_hs] = wr_addr;
        end
        n_hs++;
      end
      if (err && err_cyc < 0) err_cyc = cyc;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check("busy_after_done", int'(busy), 0);
        check("done_pulse_width", int'(done), 0);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int dc, ec, nh;
    vecs[0]  = '{0,   0, 0};
    vecs[1]  = '{5,   0, 5};
    vecs[2]  = '{33,  1, 4};
    vecs[3]  = '{34,  1, 1};
    vecs[4]  = '{36,  1, 2};
    vecs[5]  = '{43,  1, 13};
    vecs[6]  = '{65,  2, 4};
    vecs[7]  = '{68,  2, 16};
    vecs[8]  = '{77,  2, 21};
    vecs[9]  = '{95,  2, 31};
    vecs[10] = '{96,  3, 0};
    vecs[11] = '{127, 3, 31};

    rst = 1'b1; start = 1'b0; wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_rom_addr", int'(rom_addr), 0);
    check("reset_wr_ena", int'(wr_ena), 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_wr_addr", int'(wr_addr), 0);
    check("idle_wr_pass", int'(wr_pass), 0);
    check("idle_done", int'(done), 0);
    check("idle_err", int'(err), 0);

    // Clean sweep, wr_ready always high
    sweep(-1, 0, -1, -1, -1, 1'b0, dc, ec, nh);
    check("a_done_cycle", dc, 130);
    check("a_err_cycle", ec, -1);
    check("a_handshakes", nh, 128);
    verify_log("a");
    verify_table("a");
    repeat (2) @(negedge clk);

    // Three-cycle backpressure on entry 40
    sweep(40, 3, -1, -1, -1, 1'b0, dc, ec, nh);
    check("b_done_cycle", dc, 133);
    check("b_err_cycle", ec, -1);
    check("b_handshakes", nh, 128);
    verify_log("b");
    repeat (2) @(negedge clk);

    // Bad ROM word at address 33, plus start pulses while busy
    fault_addr = 33;
    sweep(-1, 0, -1, 12, 50, 1'b0, dc, ec, nh);
    fault_addr = -1;
    check("c_err_cycle", ec, 36);
    check("c_done_cycle", dc, 130);
    check("c_handshakes", nh, 128);
    check("c_err_sticky", int'(err), 1);
    verify_log("c");
    repeat (2) @(negedge clk);
    check("c_err_idle", int'(err), 1);

    // New start clears err; start coinciding with done is ignored
    sweep(-1, 0, -1, -1, -1, 1'b1, dc, ec, nh);
    check("d_done_cycle", dc, 130);
    check("d_err_cycle", ec, -1);
    check("d_handshakes", nh, 128);
    @(negedge clk);
    check("d_idle_busy", int'(busy), 0);
    check("d_idle_wr_ena", int'(wr_ena), 0);

    // Reset while entry 70 is on the write port
    sweep(-1, 0, 72, -1, -1, 1'b0, dc, ec, nh);
    check("e_handshakes", nh, 70);
    check("e_post_wr_ena", int'(wr_ena), 0);
    check("e_post_busy", int'(busy), 0);
    @(negedge clk);
    check("e_idle_wr_ena", int'(wr_ena), 0);
    check("e_idle_rom_addr", int'(rom_addr), 0);

    // Restart after reset begins again at entry 0
    sweep(-1, 0, -1, -1, -1, 1'b0, dc, ec, nh);
    check("f_done_cycle", dc, 130);
    check("f_err_cycle", ec, -1);
    check("f_handshakes", nh, 128);
    verify_log("f");
    verify_table("f");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
